// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit feeding the HI/LO registers.
// One bit per cycle: shift-add multiply, restoring divide, sign fix on the
// way into DONE. Signed ops work on magnitudes and restore signs at the end.
module mult_div_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               is_div_q;
  logic               sign_a_q, sign_b_q;
  logic               div0_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   opnd_q;     // multiplicand (mult) or divisor (div)
  logic [2*WIDTH-1:0] acc_q;      // {partial product | remainder, multiplier | dividend/quotient}
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               op_signed;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ok;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, a_restored;
  logic [WIDTH-1:0]   res_hi, res_lo;

  // Operand magnitudes and one iteration of each algorithm.
  always_comb begin
    op_signed = ~op[0];
    abs_a     = (op_signed && a[WIDTH-1]) ? -a : a;
    abs_b     = (op_signed && b[WIDTH-1]) ? -b : b;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    div_ok    = ~div_diff[WIDTH+1];
    div_rem   = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_next  = {div_rem, acc_q[WIDTH-2:0], div_ok};
  end

  // Final results with signs restored; the signs are zero for unsigned ops.
  always_comb begin
    prod_fix   = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quo_fix    = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix    = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    // On divide by zero the dividend magnitude is still untouched in acc_q.
    a_restored = sign_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    if (div0_q) begin
      res_hi = a_restored;
      res_lo = {WIDTH{1'b1}};
    end else if (is_div_q) begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. A divide by zero passes through CALC for one cycle
  // with busy masked, skipping every iteration.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CALC;
      S_CALC:  if (div0_q || cnt_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, iteration and HI/LO write-back.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      div0_q   <= 1'b0;
      cnt_q    <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            is_div_q <= op[1];
            sign_a_q <= op_signed & a[WIDTH-1];
            sign_b_q <= op_signed & b[WIDTH-1];
            div0_q   <= op[1] & (b == '0);
            cnt_q    <= CNT_W'(WIDTH);
            opnd_q   <= op[1] ? abs_b : abs_a;
            acc_q    <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
          end
        end
        S_CALC: begin
          if (div0_q || cnt_q == '0) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
          end else begin
            acc_q <= is_div_q ? div_next : mul_next;
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q == S_CALC) && !div0_q;
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO pushed at launch,
// popped and compared whenever done is seen.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a, b;
  logic        busy, done;
  logic [15:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];

  mult_div_unit #(.WIDTH(16), .CNT_W(5)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference results from plain integer arithmetic.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    longint p;
    int sx, sy, q, r;
    logic [31:0] res;
    sx = int'($signed(x));
    sy = int'($signed(y));
    res = '0;
    case (o)
      2'b00: begin p = longint'(sx) * longint'(sy); res = p[31:0]; end
      2'b01: res = {16'h0, x} * {16'h0, y};
      2'b10: begin
        if (y == 16'h0) res = {x, 16'hFFFF};
        else begin q = sx / sy; r = sx % sy; res = {r[15:0], q[15:0]}; end
      end
      default: begin
        if (y == 16'h0) res = {x, 16'hFFFF};
        else begin q = int'({16'h0, x} / {16'h0, y}); r = int'({16'h0, x} % {16'h0, y}); res = {r[15:0], q[15:0]}; end
      end
    endcase
    return res;
  endfunction

  // Output side of the scoreboard.
  always @(negedge clock) begin
    if (!reset && done) begin
      logic [31:0] e;
      done_cnt++;
      if (exp_q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("hi", {16'h0, hi}, {16'h0, e[31:16]});
        chk("lo", {16'h0, lo}, {16'h0, e[15:0]});
        $display("result hi=%h lo=%h expected hi=%h lo=%h", hi, lo, e[31:16], e[15:0]);
      end
    end
  end

  task automatic launch(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y, input bit expect_it);
    @(negedge clock);
    op = o; a = x; b = y; start = 1'b1;
    if (expect_it) begin
      exp_q.push_back(model(o, x, y));
      pushed++;
    end
    $display("launch op=%0d a=%h b=%h", o, x, y);
    @(posedge clock);
    #1;
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
  endtask

  // Waits for done, checking latency and busy duration since the launch edge.
  task automatic wait_done(input int lat0, input int busy0, input int exp_lat, input int exp_busy);
    int lat, busy_cnt;
    bit got;
    lat = lat0; busy_cnt = busy0; got = 0;
    while (lat < 60 && !got) begin
      @(posedge clock);
      #1;
      lat++;
      if (done) got = 1;
      else if (busy) busy_cnt++;
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
    chk("busy_at_done", {31'h0, busy}, 32'd0);
    @(posedge clock);
    #1;
    chk("done_one_cycle", {31'h0, done}, 32'd0);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    bit d0;
    d0 = o[1] && (y == 16'h0);
    launch(o, x, y, 1'b1);
    chk("busy_after_start", {31'h0, busy}, d0 ? 32'd0 : 32'd1);
    wait_done(0, busy ? 1 : 0, d0 ? 1 : 17, d0 ? 0 : 17);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_hilo", {hi, lo}, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    run_op(2'b01, 16'hFFFF, 16'hFFFF);
    run_op(2'b00, 16'hFFFD, 16'd7);
    run_op(2'b11, 16'd30, 16'd7);
    run_op(2'b10, 16'hFFF9, 16'd2);
    run_op(2'b11, 16'd5, 16'd0);
    run_op(2'b10, 16'hFFF9, 16'd0);
    run_op(2'b10, 16'h8000, 16'hFFFF);
    run_op(2'b00, 16'h8000, 16'h8000);

    // Second start during CALC must be ignored.
    launch(2'b01, 16'd2, 16'd28, 1'b1);
    repeat (4) @(posedge clock);
    @(negedge clock);
    op = 2'b01; a = 16'd9; b = 16'd9; start = 1'b1;
    $display("ignored start a=9 b=9");
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("busy_during_calc", {31'h0, busy}, 32'd1);
    wait_done(5, 6, 17, 17);

    // Reset in the middle of a divide clears outputs without a clock edge.
    launch(2'b10, 16'd100, 16'd3, 1'b0);
    repeat (7) @(posedge clock);
    @(negedge clock);
    chk("busy_before_reset", {31'h0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_busy", {31'h0, busy}, 32'd0);
    chk("arst_done", {31'h0, done}, 32'd0);
    chk("arst_hilo", {hi, lo}, 32'h0);
    $display("async reset applied mid-divide");
    @(negedge clock);
    reset = 1'b0;
    run_op(2'b01, 16'd2, 16'd28);

    for (int i = 0; i < 16; i++) begin
      logic [1:0]  ro;
      logic [15:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      run_op(ro, ra, rb);
    end

    @(negedge clock);
    chk("done_count", 32'(done_cnt), 32'(pushed));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
